// File: rtl/core_pkg.sv
// Shared RV32I core constants: datapath width, ALU opcodes and the
// operand / writeback select encodings used by the execute stage.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    localparam logic [1:0] WB_MEM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_IMM = 1'b0;
    localparam logic OP2_RS2 = 1'b1;

endpackage

// File: rtl/exec_alu.sv
// Combinational RV32I integer ALU. Unknown opcodes produce zero so a
// mis-decoded instruction writes a harmless value rather than garbage.
module exec_alu
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic signed [XLEN-1:0] op1_s;
    logic signed [XLEN-1:0] op2_s;
    logic        [SHW-1:0]  shamt;

    assign op1_s = op1;
    assign op2_s = op2;
    assign shamt = op2[SHW-1:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_SLL:  result = op1 << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  result = op1 ^ op2;
            ALU_SRL:  result = op1 >> shamt;
            ALU_SRA:  result = op1_s >>> shamt;
            ALU_OR:   result = op1 | op2;
            ALU_AND:  result = op1 & op2;
            ALU_PASS: result = op2;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/exec_datapath.sv
// Execute/writeback slice: operand muxes, ALU and writeback mux feed the
// core combinationally; a registered copy of result and wb data feeds trace.
module exec_datapath
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_next,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            op1_sel,
    input  logic            op2_sel,
    input  logic [3:0]      alu_op,
    input  logic [1:0]      wb_sel,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_result_q,
    output logic [XLEN-1:0] wb_data_q
);

    logic [XLEN-1:0] alu_result_d;
    logic [XLEN-1:0] wb_data_d;

    assign alu_op1 = (op1_sel == OP1_PC)  ? pc       : rs1_data;
    assign alu_op2 = (op2_sel == OP2_RS2) ? rs2_data : imm;

    exec_alu #(.XLEN(XLEN)) u_alu (
        .op1    (alu_op1),
        .op2    (alu_op2),
        .alu_op (alu_op),
        .result (alu_result)
    );

    always_comb begin
        wb_data = '0;
        case (wb_sel)
            WB_MEM:  wb_data = mem_rdata;
            WB_ALU:  wb_data = alu_result;
            WB_PC:   wb_data = pc_next;
            default: wb_data = '0;
        endcase
    end

    // Trace capture stage: hold when not enabled, reset wins over enable
    assign alu_result_d = en ? alu_result : alu_result_q;
    assign wb_data_d    = en ? wb_data    : wb_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= '0;
            wb_data_q    <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            wb_data_q    <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_exec_datapath.sv
// Randomized scoreboard bench for exec_datapath with directed corner cases.
module tb_exec_datapath;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [31:0] rs1_data, rs2_data, pc, pc_next, imm, mem_rdata;
    logic        op1_sel, op2_sel;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [31:0] alu_op1, alu_op2, alu_result, wb_data, alu_result_q, wb_data_q;

    always #5 clk = ~clk;

    exec_datapath dut (
        .clk(clk), .rst(rst), .en(en),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .pc_next(pc_next),
        .imm(imm), .mem_rdata(mem_rdata), .op1_sel(op1_sel), .op2_sel(op2_sel),
        .alu_op(alu_op), .wb_sel(wb_sel),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
        .wb_data(wb_data), .alu_result_q(alu_result_q), .wb_data_q(wb_data_q)
    );

    typedef struct {
        logic [31:0] op1, op2, res, wb, q_res, q_wb;
        bit          lit_res_chk, lit_wb_chk;
        logic [31:0] lit_res, lit_wb;
    } item_t;

    item_t sbq[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written from the instruction-level definitions.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int unsigned s;
        longint sa, sb;
        logic [63:0] ext;
        s  = b % 32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ext = {{32{a[31]}}, a};
        case (op)
            4'b0000: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'b1000: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            4'b0001: return 32'((64'(a) * (64'd1 << s)) % 64'h1_0000_0000);
            4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return 32'(64'(a) / (64'd1 << s));
            4'b1101: return ext[31+s -: 32];
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1111: return b;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] m_q_res = 32'd0;
    logic [31:0] m_q_wb  = 32'd0;

    task automatic drive(input logic r, input logic e,
                         input logic [31:0] a_rs1, input logic [31:0] a_rs2,
                         input logic [31:0] a_pc, input logic [31:0] a_pcn,
                         input logic [31:0] a_imm, input logic [31:0] a_mem,
                         input logic s1, input logic s2, input logic [3:0] op,
                         input logic [1:0] ws,
                         input bit lr, input logic [31:0] lres,
                         input bit lw, input logic [31:0] lwb);
        item_t it;
        @(posedge clk);
        #1;
        rst = r; en = e; rs1_data = a_rs1; rs2_data = a_rs2; pc = a_pc;
        pc_next = a_pcn; imm = a_imm; mem_rdata = a_mem; op1_sel = s1;
        op2_sel = s2; alu_op = op; wb_sel = ws;
        it.op1 = s1 ? a_pc : a_rs1;
        it.op2 = s2 ? a_rs2 : a_imm;
        it.res = ref_alu(it.op1, it.op2, op);
        it.wb  = (ws == 2'd0) ? a_mem : (ws == 2'd1) ? it.res : (ws == 2'd2) ? a_pcn : 32'd0;
        if (r) begin
            m_q_res = 32'd0; m_q_wb = 32'd0;
        end else if (e) begin
            m_q_res = it.res; m_q_wb = it.wb;
        end
        it.q_res = m_q_res;
        it.q_wb  = m_q_wb;
        it.lit_res_chk = lr; it.lit_res = lres;
        it.lit_wb_chk  = lw; it.lit_wb  = lwb;
        sbq.push_back(it);
    endtask

    // Monitor: comb outputs checked mid-cycle, registered ones one edge later
    item_t pend;
    bit    pend_v = 1'b0;
    always @(negedge clk) begin
        if (pend_v) begin
            chk("alu_result_q", alu_result_q, pend.q_res);
            chk("wb_data_q", wb_data_q, pend.q_wb);
            pend_v = 1'b0;
        end
        if (sbq.size() > 0) begin
            pend = sbq.pop_front();
            pend_v = 1'b1;
            chk("alu_op1", alu_op1, pend.op1);
            chk("alu_op2", alu_op2, pend.op2);
            chk("alu_result", alu_result, pend.res);
            chk("wb_data", wb_data, pend.wb);
            if (pend.lit_res_chk) chk("alu_result_lit", alu_result, pend.lit_res);
            if (pend.lit_wb_chk)  chk("wb_data_lit", wb_data, pend.lit_wb);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; rs1_data = '0; rs2_data = '0; pc = '0; pc_next = '0;
        imm = '0; mem_rdata = '0; op1_sel = 1'b0; op2_sel = 1'b0; alu_op = '0; wb_sel = '0;

        // Reset for two edges, registered outputs must read zero
        drive(1, 1, 32'h11, 32'h22, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b01, 0, 0, 0, 0);
        drive(1, 0, 32'h33, 32'h44, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b01, 0, 0, 0, 0);
        // Arithmetic
        drive(0, 1, 5, 7, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b01, 1, 32'h0000000C, 1, 32'h0000000C);
        drive(0, 1, 3, 5, 0, 0, 0, 0, 0, 1, 4'b1000, 2'b01, 1, 32'hFFFFFFFE, 0, 0);
        // AUIPC
        drive(0, 1, 32'h55, 32'h66, 32'h100, 32'h104, 32'h1000, 0, 1, 0, 4'b0000, 2'b01,
              1, 32'h1100, 1, 32'h1100);
        // Shifts, only low five bits of shamt
        drive(0, 1, 32'h80000000, 32'h24, 0, 0, 0, 0, 0, 1, 4'b1101, 2'b01, 1, 32'hF8000000, 0, 0);
        drive(0, 1, 32'h80000000, 32'h24, 0, 0, 0, 0, 0, 1, 4'b0101, 2'b01, 1, 32'h08000000, 0, 0);
        drive(0, 1, 32'h1, 32'd31, 0, 0, 0, 0, 0, 1, 4'b0001, 2'b01, 1, 32'h80000000, 0, 0);
        // Compares, PASS and an unused opcode
        drive(0, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 1, 4'b0010, 2'b01, 1, 32'd1, 0, 0);
        drive(0, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 1, 4'b0011, 2'b01, 1, 32'd0, 0, 0);
        drive(0, 1, 32'hFFFFFFFF, 1, 0, 0, 32'h12345000, 0, 0, 0, 4'b1111, 2'b01, 1, 32'h12345000, 0, 0);
        drive(0, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 1, 4'b1001, 2'b01, 1, 32'd0, 0, 0);
        // Writeback selects
        drive(0, 1, 9, 9, 0, 32'h104, 0, 32'hDEADBEEF, 0, 1, 4'b0000, 2'b00, 0, 0, 1, 32'hDEADBEEF);
        drive(0, 1, 9, 9, 0, 32'h104, 0, 32'hDEADBEEF, 0, 1, 4'b0000, 2'b10, 0, 0, 1, 32'h104);
        drive(0, 1, 9, 9, 0, 32'h104, 0, 32'hDEADBEEF, 0, 1, 4'b0000, 2'b11, 0, 0, 1, 32'd0);
        // Register capture, hold, and reset overriding enable
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b01, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b01, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b01, 1, 32'd2, 1, 32'd2);
        drive(0, 0, 7, 8, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b01, 1, 32'd15, 0, 0);
        drive(0, 0, 9, 8, 0, 0, 0, 0, 0, 1, 4'b0110, 2'b00, 0, 0, 0, 0);
        drive(1, 1, 7, 8, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b01, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            logic [31:0] b;
            op = 4'($urandom);
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  $urandom, b, $urandom, $urandom, $urandom, $urandom,
                  1'($urandom), 1'($urandom), op, 2'($urandom), 0, 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() != 0 || pend_v) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
